// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage core: combinational hold/pause/flush controls,
// a small action-history FSM, a memory-wait watchdog and saturating perf counters.
module hazard_ctrl #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       ID_rs1_addr,
    input  logic [4:0]       ID_rs2_addr,
    input  logic             ID_rs1_used,
    input  logic             ID_rs2_used,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rd_addr,
    input  logic             EX_Redirect,
    input  logic             MEM_Busy,
    input  logic             perf_clr,
    output logic             PC_Hold,
    output logic             IF_ID_Hold,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Pause,
    output logic             ID_EX_Flush,
    output logic             ID_EX_Hold,
    output logic             EX_MEM_Hold,
    output logic             MEM_WB_Bubble,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FREEZE   = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_TRIP = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t            state_q;
    state_t            state_d;
    logic              lu;
    logic [WAIT_W-1:0] wait_cnt;

    assign lu = EX_MemRead && (EX_rd_addr != 5'd0) &&
                ((ID_rs1_used && (ID_rs1_addr == EX_rd_addr)) ||
                 (ID_rs2_used && (ID_rs2_addr == EX_rd_addr)));

    // The next state is simply the class of this cycle's action, so state reports history.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rstn) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        state_d = RUN;
        if (MEM_Busy)         state_d = FREEZE;
        else if (EX_Redirect) state_d = FLUSH;
        else if (lu)          state_d = LU_STALL;
    end

    // Controls decode this cycle's action directly; there is no register on this path.
    always_comb begin
        PC_Hold       = 1'b0;
        IF_ID_Hold    = 1'b0;
        IF_ID_Flush   = 1'b0;
        ID_EX_Pause   = 1'b0;
        ID_EX_Flush   = 1'b0;
        ID_EX_Hold    = 1'b0;
        EX_MEM_Hold   = 1'b0;
        MEM_WB_Bubble = 1'b0;
        if (rstn) begin
            unique case (state_d)
                FREEZE: begin
                    PC_Hold       = 1'b1;
                    IF_ID_Hold    = 1'b1;
                    ID_EX_Hold    = 1'b1;
                    EX_MEM_Hold   = 1'b1;
                    MEM_WB_Bubble = 1'b1;
                end
                FLUSH: begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                end
                LU_STALL: begin
                    PC_Hold     = 1'b1;
                    IF_ID_Hold  = 1'b1;
                    ID_EX_Pause = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

    // Watchdog only flags a stuck memory; the freeze itself is never released by it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (MEM_Busy) begin
            if (wait_cnt == WAIT_TRIP) mem_timeout <= 1'b1;
            if (wait_cnt != WAIT_MAX)  wait_cnt    <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || perf_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((state_d == FREEZE || state_d == LU_STALL) && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + 1'b1;
            if (state_d == FLUSH && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
